// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner: FSM state encoding and the
// active-high hex-to-segment table ({g,f,e,d,c,b,a}, bit 0 = a).
package sevenseg_pkg;

  localparam int CNT_W = 23;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_scan_hex_to_seg.sv
// Combinational nibble-to-segment decoder; output is active-high, polarity is
// applied by the caller at the output flops.
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment driver: shadow/display double buffer committed at
// the frame boundary, and a SHOW/GUARD scan FSM with registered pin drive.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int               DIGITS       = 4,
  parameter logic [CNT_W-1:0] SCAN_WAIT    = 23'd49999,
  parameter logic [7:0]       GUARD_CYCLES = 8'd50,
  parameter bit               ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic                  pending,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_CYCLES) - 23'd1;
  localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF    = {7{ACTIVE_LOW}};
  localparam logic              DP_OFF     = ACTIVE_LOW;

  scan_state_t                state;
  logic [IDX_W-1:0]           idx;
  logic [CNT_W-1:0]           cnt;
  logic                       started;
  logic [DIGITS-1:0][3:0]     shadow_val, disp_val;
  logic [DIGITS-1:0]          shadow_dp, disp_dp;
  logic [DIGITS-1:0]          shadow_blank, disp_blank;

  logic                       show_done, guard_done, frame_edge, commit;
  logic [IDX_W-1:0]           next_idx;
  logic [DIGITS-1:0][3:0]     eff_val;
  logic [DIGITS-1:0]          eff_dp, eff_blank;
  logic [DIGITS-1:0]          lit_an;
  logic [3:0]                 nibble;
  logic [6:0]                 dec_seg, lit_seg;
  logic                       lit_dp;

  // The data decoded here is what the digit about to be entered will show, so a
  // commit on this same edge must already be visible in the new pin values.
  always_comb begin
    show_done  = (state == ST_SHOW)  && (cnt == SCAN_WAIT);
    guard_done = (state == ST_GUARD) && (cnt == GUARD_LAST);
    next_idx   = (!started || idx == IDX_LAST) ? '0 : idx + 1'b1;
    frame_edge = guard_done && (next_idx == '0);
    commit     = frame_edge && pending;
    eff_val    = commit ? shadow_val   : disp_val;
    eff_dp     = commit ? shadow_dp    : disp_dp;
    eff_blank  = commit ? shadow_blank : disp_blank;
    nibble     = eff_val[next_idx];
    lit_an           = '0;
    lit_an[next_idx] = ~eff_blank[next_idx];
    lit_seg    = eff_blank[next_idx] ? SEG_BLANK : dec_seg;
    lit_dp     = eff_dp[next_idx] & ~eff_blank[next_idx];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; the commit copies the old shadow even when load hits the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_GUARD;
      idx          <= '0;
      cnt          <= '0;
      started      <= 1'b0;
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
      an           <= AN_OFF;
      seg          <= SEG_OFF;
      dp           <= DP_OFF;
    end else begin
      if (load) begin
        shadow_val   <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_mask;
      end
      pending <= load | (pending & ~frame_edge);
      if (commit) begin
        disp_val   <= shadow_val;
        disp_dp    <= shadow_dp;
        disp_blank <= shadow_blank;
      end

      case (state)
        ST_SHOW: begin
          if (show_done) begin
            state <= ST_GUARD;
            cnt   <= '0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            dp    <= DP_OFF;
          end else begin
            cnt <= cnt + 23'd1;
          end
        end
        default: begin
          if (guard_done) begin
            state   <= ST_SHOW;
            cnt     <= '0;
            idx     <= next_idx;
            started <= 1'b1;
            an      <= lit_an  ^ AN_OFF;
            seg     <= lit_seg ^ SEG_OFF;
            dp      <= lit_dp  ^ DP_OFF;
          end else begin
            cnt <= cnt + 23'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with DIGITS=4, SCAN_WAIT=3, GUARD_CYCLES=1,
// ACTIVE_LOW=0: slot = 5 clk, frame = 20 clk.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        pending;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;

  sevenseg_scan #(
    .DIGITS       (4),
    .SCAN_WAIT    (23'd3),
    .GUARD_CYCLES (8'd1),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .pending    (pending),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At most one anode lit, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) check("onehot_an", 32'($countones(an) <= 1), 32'd1);
  end

  // One clock edge; outputs are sampled 1 time unit later. load is a 1-cycle strobe.
  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load       = 1'b1;
    value      = v;
    dp_in      = d;
    blank_mask = b;
  endtask

  // One slot: 4 SHOW cycles for digit d, then 1 GUARD cycle with everything off.
  task automatic check_slot(input int d, input logic [6:0] s, input logic p, input logic blank);
    logic [3:0] exp_an;
    exp_an = blank ? 4'b0000 : (4'b0001 << d);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("slot%0d_an", d), 32'(an), 32'(exp_an));
      if (!blank) begin
        check($sformatf("slot%0d_seg", d), 32'(seg), 32'(s));
        check($sformatf("slot%0d_dp", d), 32'(dp), 32'(p));
      end
    end
    step();
    check($sformatf("guard%0d_an", d), 32'(an), 32'd0);
    check($sformatf("guard%0d_seg", d), 32'(seg), 32'd0);
    check($sformatf("guard%0d_dp", d), 32'(dp), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    blank_mask = '0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state, then the scan sequence on zero data
    check("rst_an", 32'(an), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset = 1'b1;
    check("post_rst_an", 32'(an), 32'd0);
    check_slot(0, 7'h3F, 1'b0, 1'b0);
    check_slot(1, 7'h3F, 1'b0, 1'b0);

    // 2: mid-frame load stays pending; display unchanged until next frame
    do_load(16'h12AF, 4'b0100, 4'b0000);
    step();
    check("load_pending", 32'(pending), 32'd1);
    check("load_an_still_d2", 32'(an), 32'b0100);
    check("load_seg_still_0", 32'(seg), 32'h3F);
    for (int c = 0; c < 3; c++) step();
    step();
    check_slot(3, 7'h3F, 1'b0, 1'b0);
    check("pending_before_boundary", 32'(pending), 32'd1);
    check_slot(0, 7'h71, 1'b0, 1'b0);
    check("pending_cleared", 32'(pending), 32'd0);

    // 3: two loads in one frame; only the last one survives
    do_load(16'h1111, 4'b0000, 4'b0000);
    check_slot(1, 7'h77, 1'b0, 1'b0);
    do_load(16'h2222, 4'b0000, 4'b0000);
    check_slot(2, 7'h5B, 1'b1, 1'b0);
    check_slot(3, 7'h06, 1'b0, 1'b0);
    check_slot(0, 7'h5B, 1'b0, 1'b0);
    check_slot(1, 7'h5B, 1'b0, 1'b0);

    // 4: load on the boundary edge; old shadow shows, new data one frame later
    do_load(16'h4444, 4'b0000, 4'b0000);
    check_slot(2, 7'h5B, 1'b0, 1'b0);
    check_slot(3, 7'h5B, 1'b0, 1'b0);
    do_load(16'h5555, 4'b0000, 4'b0000);
    check_slot(0, 7'h66, 1'b0, 1'b0);
    check("boundary_load_pending", 32'(pending), 32'd1);
    check_slot(1, 7'h66, 1'b0, 1'b0);
    check_slot(2, 7'h66, 1'b0, 1'b0);
    check_slot(3, 7'h66, 1'b0, 1'b0);
    check_slot(0, 7'h6D, 1'b0, 1'b0);
    check("boundary_load_committed", 32'(pending), 32'd0);

    // 5: blank mask 1010 darkens digits 1 and 3 with timing unchanged
    do_load(16'h6789, 4'b0000, 4'b1010);
    check_slot(1, 7'h6D, 1'b0, 1'b0);
    check_slot(2, 7'h6D, 1'b0, 1'b0);
    check_slot(3, 7'h6D, 1'b0, 1'b0);
    check_slot(0, 7'h6F, 1'b0, 1'b0);
    check_slot(1, 7'h00, 1'b0, 1'b1);
    check_slot(2, 7'h07, 1'b0, 1'b0);
    check_slot(3, 7'h00, 1'b0, 1'b1);
    check_slot(0, 7'h6F, 1'b0, 1'b0);
    check_slot(1, 7'h00, 1'b0, 1'b1);

    // 6: async reset during SHOW of digit 2, then restart from digit 0 with zero data
    do_load(16'hBEEF, 4'b1111, 4'b0000);
    step();
    step();
    check("pre_reset_an", 32'(an), 32'b0100);
    check("pre_reset_seg", 32'(seg), 32'h07);
    check("pre_reset_pending", 32'(pending), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'd0);
    check("async_rst_seg", 32'(seg), 32'd0);
    check("async_rst_dp", 32'(dp), 32'd0);
    check("async_rst_pending", 32'(pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check("restart_an", 32'(an), 32'd0);
    check_slot(0, 7'h3F, 1'b0, 1'b0);
    check_slot(1, 7'h3F, 1'b0, 1'b0);
    check_slot(2, 7'h3F, 1'b0, 1'b0);
    check_slot(3, 7'h3F, 1'b0, 1'b0);
    check("restart_pending", 32'(pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
